forth_io_port: RTL and testbench

//  Memory-mapped I/O peripheral on the Forth core's io bus (io_addr/io_dout/io_rd/io_wr -> io_din).

---
 rtl/forth_io_pkg.sv | 29 ++
 rtl/forth_io_fifo.sv | 47 ++++
 rtl/forth_io_port.sv | 158 +++++++++++++++
 tb/tb_forth_io_port.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/forth_io_pkg.sv
// Shared constants for the Forth core I/O port:
// register offsets, STATUS/CTRL bit positions, reset values.
package forth_io_pkg;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_TIMER  = 3'd3;
  localparam logic [2:0] REG_TCMP   = 3'd4;
  localparam logic [2:0] REG_LAST   = 3'd4;

  localparam int ST_RX_EMPTY = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_FULL  = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_UNF   = 5;
  localparam int ST_TMR_HIT  = 6;

  localparam int CT_TMR_EN  = 0;
  localparam int CT_IE_OVF  = 1;
  localparam int CT_IE_UNF  = 2;
  localparam int CT_IE_TMR  = 3;
  localparam int CT_IE_RXNE = 4;
  localparam int CTRL_W     = 5;

  localparam logic [15:0] TCMP_RST = 16'hFFFF;

endpackage

// File: rtl/forth_io_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Push and pop may coincide at any occupancy.
module forth_io_fifo #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  output logic [DW-1:0] o_rdata,
  output logic          o_full,
  output logic          o_empty
);

  logic [DW-1:0] r_mem [0:(2**AW)-1];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          w_pop;
  logic          w_push;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // a pop frees the slot a same-cycle push needs when full
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  assign o_rdata = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/forth_io_port.sv
// Memory-mapped I/O port for the Forth core: TX/RX FIFOs,
// status/control registers, compare timer and level interrupt.
module forth_io_port
  import forth_io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          DW        = 16,
  parameter int          FIFO_AW   = 3
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
  input  logic [15:0]   io_addr,
  input  logic [DW-1:0] io_dout,
  input  logic          io_rd,
  input  logic          io_wr,
  output logic [DW-1:0] io_din,
  output logic [DW-1:0] tx_data_o,
  output logic          tx_valid_o,
  input  logic          tx_ready_i,
  input  logic [DW-1:0] rx_data_i,
  input  logic          rx_valid_i,
  output logic          rx_ready_o,
  output logic          irq_o
);

  logic [15:0]       w_off;
  logic              w_hit;
  logic              w_wr;
  logic              w_rd;
  logic              w_sel_data;
  logic              w_sel_stat;
  logic              w_sel_ctrl;
  logic              w_sel_tmr;
  logic              w_sel_tcmp;
  logic              w_tx_full;
  logic              w_tx_empty;
  logic              w_tx_push;
  logic              w_tx_pop;
  logic              w_rx_full;
  logic              w_rx_empty;
  logic              w_rx_pop;
  logic              w_rx_push;
  logic [DW-1:0]     w_rx_head;
  logic [DW-1:0]     w_rdata;
  logic [2:0]        w_clr;
  logic              w_ovf_set;
  logic              w_unf_set;
  logic              w_hit_set;
  logic [DW-1:0]     r_io_din;
  logic [CTRL_W-1:0] r_ctrl;
  logic [15:0]       r_timer;
  logic [15:0]       r_tcmp;
  logic              r_tx_ovf;
  logic              r_rx_unf;
  logic              r_tmr_hit;
  logic              r_irq;

  assign w_off = io_addr - BASE_ADDR;
  assign w_hit = (w_off <= {13'd0, REG_LAST});

  assign w_sel_data = w_hit && (w_off[2:0] == REG_DATA);
  assign w_sel_stat = w_hit && (w_off[2:0] == REG_STATUS);
  assign w_sel_ctrl = w_hit && (w_off[2:0] == REG_CTRL);
  assign w_sel_tmr  = w_hit && (w_off[2:0] == REG_TIMER);
  assign w_sel_tcmp = w_hit && (w_off[2:0] == REG_TCMP);

  // a read colliding with a write is dropped entirely
  assign w_wr = io_wr;
  assign w_rd = io_rd & ~io_wr;

  assign w_tx_pop  = tx_valid_o & tx_ready_i;
  assign w_tx_push = w_wr & w_sel_data;
  assign tx_valid_o = ~w_tx_empty;

  assign w_rx_pop   = w_rd & w_sel_data & ~w_rx_empty;
  assign rx_ready_o = ~w_rx_full | w_rx_pop;
  assign w_rx_push  = rx_valid_i & rx_ready_o;

  assign w_ovf_set = w_tx_push & w_tx_full & ~w_tx_pop;
  assign w_unf_set = w_rd & w_sel_data & w_rx_empty;
  assign w_hit_set = (r_timer == r_tcmp);
  assign w_clr     = (w_wr & w_sel_stat) ? io_dout[6:4] : 3'b000;

  forth_io_fifo #(.DW(DW), .AW(FIFO_AW)) u_tx_fifo (
    .i_clk   (sys_clk_i),
    .i_rst_n (sys_rst_i),
    .i_push  (w_tx_push),
    .i_wdata (io_dout),
    .i_pop   (w_tx_pop),
    .o_rdata (tx_data_o),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  forth_io_fifo #(.DW(DW), .AW(FIFO_AW)) u_rx_fifo (
    .i_clk   (sys_clk_i),
    .i_rst_n (sys_rst_i),
    .i_push  (w_rx_push),
    .i_wdata (rx_data_i),
    .i_pop   (w_rx_pop),
    .o_rdata (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_sel_data: w_rdata = w_rx_head;
      w_sel_stat: begin
        w_rdata[ST_RX_EMPTY] = w_rx_empty;
        w_rdata[ST_RX_FULL]  = w_rx_full;
        w_rdata[ST_TX_EMPTY] = w_tx_empty;
        w_rdata[ST_TX_FULL]  = w_tx_full;
        w_rdata[ST_TX_OVF]   = r_tx_ovf;
        w_rdata[ST_RX_UNF]   = r_rx_unf;
        w_rdata[ST_TMR_HIT]  = r_tmr_hit;
      end
      w_sel_ctrl: w_rdata[CTRL_W-1:0] = r_ctrl;
      w_sel_tmr:  w_rdata[15:0] = r_timer;
      w_sel_tcmp: w_rdata[15:0] = r_tcmp;
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_io_din  <= '0;
      r_ctrl    <= '0;
      r_timer   <= '0;
      r_tcmp    <= TCMP_RST;
      r_tx_ovf  <= 1'b0;
      r_rx_unf  <= 1'b0;
      r_tmr_hit <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_rd) r_io_din <= w_rdata;
      if (w_wr & w_sel_ctrl) r_ctrl <= io_dout[CTRL_W-1:0];
      if (w_wr & w_sel_tcmp) r_tcmp <= io_dout[15:0];
      if (w_wr & w_sel_tmr)
        r_timer <= io_dout[15:0];
      else if (r_ctrl[CT_TMR_EN])
        r_timer <= r_timer + 16'd1;
      // set beats a same-cycle clear
      r_tx_ovf  <= w_ovf_set | (r_tx_ovf  & ~w_clr[0]);
      r_rx_unf  <= w_unf_set | (r_rx_unf  & ~w_clr[1]);
      r_tmr_hit <= w_hit_set | (r_tmr_hit & ~w_clr[2]);
      r_irq <= (r_tx_ovf  & r_ctrl[CT_IE_OVF]) |
               (r_rx_unf  & r_ctrl[CT_IE_UNF]) |
               (r_tmr_hit & r_ctrl[CT_IE_TMR]) |
               (~w_rx_empty & r_ctrl[CT_IE_RXNE]);
    end
  end

  assign io_din = r_io_din;
  assign irq_o  = r_irq;

endmodule

// File: tb/tb_forth_io_port.sv
// Bench for forth_io_port: register table, directed corner
// sequences, then random traffic against a queue-based model.
module tb_forth_io_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] io_addr = '0;
  logic [15:0] io_dout = '0;
  logic        io_rd = 1'b0;
  logic        io_wr = 1'b0;
  logic [15:0] io_din;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [15:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  forth_io_port dut (
    .sys_clk_i  (clk),
    .sys_rst_i  (rst_n),
    .io_addr    (io_addr),
    .io_dout    (io_dout),
    .io_rd      (io_rd),
    .io_wr      (io_wr),
    .io_din     (io_din),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rx_ready_o (rx_ready),
    .irq_o      (irq)
  );

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    io_addr = a; io_dout = d; io_wr = 1'b1; io_rd = 1'b0;
    cyc();
    io_wr = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] v);
    io_addr = a; io_rd = 1'b1; io_wr = 1'b0;
    cyc();
    io_rd = 1'b0;
    v = io_din;
  endtask

  task automatic do_reset();
    io_rd = 1'b0; io_wr = 1'b0;
    tx_ready = 1'b0; rx_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    cyc();
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [17];

  logic [15:0] mtq [$];
  logic [15:0] mrq [$];
  logic        m_ovf, m_unf, m_hit, m_irq;
  logic [4:0]  m_ctrl;
  logic [15:0] m_timer, m_tcmp, m_din;

  function automatic logic [15:0] m_status();
    return {9'd0, m_hit, m_unf, m_ovf,
            mtq.size() == 8, mtq.size() == 0,
            mrq.size() == 8, mrq.size() == 0};
  endfunction

  task automatic model_reset();
    mtq.delete(); mrq.delete();
    m_ovf = 0; m_unf = 0; m_hit = 0; m_irq = 0;
    m_ctrl = '0; m_timer = '0; m_tcmp = 16'hFFFF; m_din = '0;
  endtask

  task automatic model_step();
    logic [15:0] off;
    logic        hit, wr_, rd_, txp, rxp, txa, rxa;
    logic        so, su, sh, irqn;
    logic [2:0]  clr;
    logic [15:0] nt;
    off  = io_addr - 16'hFF00;
    hit  = off < 5;
    wr_  = io_wr && hit;
    rd_  = io_rd && !io_wr;
    txp  = mtq.size() > 0 && tx_ready;
    txa  = wr_ && off == 0 && (mtq.size() < 8 || txp);
    so   = wr_ && off == 0 && !txa;
    rxp  = rd_ && hit && off == 0 && mrq.size() > 0;
    su   = rd_ && hit && off == 0 && mrq.size() == 0;
    rxa  = rx_valid && (mrq.size() < 8 || rxp);
    sh   = m_timer == m_tcmp;
    clr  = (wr_ && off == 1) ? io_dout[6:4] : 3'b0;
    irqn = (m_ovf & m_ctrl[1]) | (m_unf & m_ctrl[2]) |
           (m_hit & m_ctrl[3]) | (mrq.size() > 0 && m_ctrl[4]);
    if (rd_) begin
      if (!hit) m_din = 0;
      else case (off)
        0: m_din = mrq.size() > 0 ? mrq[0] : 16'h0;
        1: m_din = m_status();
        2: m_din = {11'd0, m_ctrl};
        3: m_din = m_timer;
        default: m_din = m_tcmp;
      endcase
    end
    nt = m_timer + (m_ctrl[0] ? 16'd1 : 16'd0);
    if (wr_ && off == 3) nt = io_dout;
    m_timer = nt;
    if (wr_ && off == 2) m_ctrl = io_dout[4:0];
    if (wr_ && off == 4) m_tcmp = io_dout;
    m_ovf = so | (m_ovf & !clr[0]);
    m_unf = su | (m_unf & !clr[1]);
    m_hit = sh | (m_hit & !clr[2]);
    m_irq = irqn;
    if (txp) void'(mtq.pop_front());
    if (txa) mtq.push_back(io_dout);
    if (rxp) void'(mrq.pop_front());
    if (rxa) mrq.push_back(rx_data);
  endtask

  logic [15:0] v;

  initial begin
    tbl[0]  = '{2'd0, 16'hFF02, 16'h001F, 16'h0000};
    tbl[1]  = '{2'd1, 16'hFF02, 16'h0000, 16'h001F};
    tbl[2]  = '{2'd0, 16'hFF02, 16'hFFE0, 16'h0000};
    tbl[3]  = '{2'd1, 16'hFF02, 16'h0000, 16'h0000};
    tbl[4]  = '{2'd0, 16'hFF04, 16'h1234, 16'h0000};
    tbl[5]  = '{2'd1, 16'hFF04, 16'h0000, 16'h1234};
    tbl[6]  = '{2'd2, 16'hFF04, 16'h0000, 16'h1234};
    tbl[7]  = '{2'd0, 16'hFF05, 16'h5555, 16'h0000};
    tbl[8]  = '{2'd1, 16'hFF05, 16'h0000, 16'h0000};
    tbl[9]  = '{2'd1, 16'hFEFF, 16'h0000, 16'h0000};
    tbl[10] = '{2'd0, 16'hFF03, 16'h0ABC, 16'h0000};
    tbl[11] = '{2'd1, 16'hFF03, 16'h0000, 16'h0ABC};
    tbl[12] = '{2'd3, 16'hFF04, 16'h4321, 16'h0ABC};
    tbl[13] = '{2'd1, 16'hFF04, 16'h0000, 16'h4321};
    tbl[14] = '{2'd1, 16'hFF01, 16'h0000, 16'h0005};
    tbl[15] = '{2'd0, 16'hFF01, 16'hFFFF, 16'h0000};
    tbl[16] = '{2'd1, 16'hFF01, 16'h0000, 16'h0005};

    #2;
    chk("rst io_din", io_din, 16'h0);
    chk("rst tx_valid", {15'd0, tx_valid}, 16'h0);
    chk("rst irq", {15'd0, irq}, 16'h0);
    chk("rst rx_ready", {15'd0, rx_ready}, 16'h1);
    #10;
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 17; i++) begin
      io_addr = tbl[i].addr;
      io_dout = tbl[i].data;
      io_wr = (tbl[i].op == 2'd0 || tbl[i].op == 2'd3);
      io_rd = (tbl[i].op == 2'd1 || tbl[i].op == 2'd3);
      cyc();
      io_wr = 1'b0; io_rd = 1'b0;
      if (tbl[i].op != 2'd0)
        chk($sformatf("tbl[%0d]", i), io_din, tbl[i].exp);
    end

    // TX ordering and STATUS
    do_reset();
    wr(16'hFF00, 16'h1234);
    wr(16'hFF00, 16'hABCD);
    chk("t1 valid", {15'd0, tx_valid}, 16'h1);
    chk("t1 head", tx_data, 16'h1234);
    rd(16'hFF01, v);
    chk("t1 status", v, 16'h0001);
    tx_ready = 1'b1;
    cyc();
    chk("t1 second", tx_data, 16'hABCD);
    cyc();
    chk("t1 drained", {15'd0, tx_valid}, 16'h0);
    tx_ready = 1'b0;

    // TX overflow
    for (int i = 0; i < 9; i++) wr(16'hFF00, 16'h0100 + 16'(i));
    rd(16'hFF01, v);
    chk("t2 status ovf", v, 16'h0019);
    wr(16'hFF01, 16'h0010);
    rd(16'hFF01, v);
    chk("t2 ovf clear", v, 16'h0009);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2 drain%0d", i), tx_data, 16'h0100 + 16'(i));
      cyc();
    end
    chk("t2 empty", {15'd0, tx_valid}, 16'h0);
    tx_ready = 1'b0;

    // RX fill, drain, underflow
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 16'(i);
      cyc();
    end
    rx_valid = 1'b0;
    chk("t3 rx_ready", {15'd0, rx_ready}, 16'h0);
    for (int i = 0; i < 8; i++) begin
      rd(16'hFF00, v);
      chk($sformatf("t3 rd%0d", i), v, 16'(i));
    end
    rd(16'hFF00, v);
    chk("t3 unf data", v, 16'h0);
    rd(16'hFF01, v);
    chk("t3 unf status", v, 16'h0025);
    wr(16'hFF01, 16'h0020);

    // timer compare, interrupt, wrap
    wr(16'hFF04, 16'h0005);
    wr(16'hFF02, 16'h0009);
    for (int i = 0; i < 10; i++) cyc();
    chk("t4 irq", {15'd0, irq}, 16'h1);
    rd(16'hFF01, v);
    chk("t4 hit", v, 16'h0045);
    wr(16'hFF01, 16'h0040);
    cyc();
    chk("t4 irq clr", {15'd0, irq}, 16'h0);
    wr(16'hFF02, 16'h0000);
    wr(16'hFF03, 16'hFFFF);
    wr(16'hFF02, 16'h0001);
    rd(16'hFF03, v);
    chk("t4 tmr ffff", v, 16'hFFFF);
    rd(16'hFF03, v);
    chk("t4 tmr wrap", v, 16'h0000);
    wr(16'hFF02, 16'h0000);

    // RX simultaneous push/pop at full and empty
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 16'h0050 + 16'(i);
      cyc();
    end
    rx_data = 16'h0058;
    io_addr = 16'hFF00; io_rd = 1'b1;
    #1;
    chk("t5 ready full+pop", {15'd0, rx_ready}, 16'h1);
    cyc();
    io_rd = 1'b0; rx_valid = 1'b0;
    chk("t5 pop head", io_din, 16'h0050);
    rd(16'hFF01, v);
    chk("t5 still full", v, 16'h0006);
    for (int i = 1; i < 9; i++) begin
      rd(16'hFF00, v);
      chk($sformatf("t5 order%0d", i), v, 16'h0050 + 16'(i));
    end
    rx_valid = 1'b1; rx_data = 16'h0077;
    io_addr = 16'hFF00; io_rd = 1'b1;
    cyc();
    io_rd = 1'b0; rx_valid = 1'b0;
    chk("t5 empty rd", io_din, 16'h0);
    rd(16'hFF01, v);
    chk("t5 unf kept", v, 16'h0024);
    rd(16'hFF00, v);
    chk("t5 retained", v, 16'h0077);
    wr(16'hFF01, 16'h0020);

    // reset mid-drain
    wr(16'hFF02, 16'h0010);
    rx_valid = 1'b1; rx_data = 16'h00EE;
    cyc();
    rx_valid = 1'b0;
    cyc();
    chk("t6 irq pre", {15'd0, irq}, 16'h1);
    for (int i = 0; i < 3; i++) wr(16'hFF00, 16'h0200 + 16'(i));
    tx_ready = 1'b1;
    cyc();
    rst_n = 1'b0;
    #1;
    chk("t6 tx_valid", {15'd0, tx_valid}, 16'h0);
    chk("t6 io_din", io_din, 16'h0);
    chk("t6 irq", {15'd0, irq}, 16'h0);
    chk("t6 rx_ready", {15'd0, rx_ready}, 16'h1);
    #2;
    rst_n = 1'b1;
    tx_ready = 1'b0;
    cyc();
    chk("t6 tx empty", {15'd0, tx_valid}, 16'h0);
    rd(16'hFF01, v);
    chk("t6 status", v, 16'h0005);
    rd(16'hFF02, v);
    chk("t6 ctrl", v, 16'h0000);
    rd(16'hFF04, v);
    chk("t6 tcmp", v, 16'hFFFF);

    // random traffic against the model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      int ar, op;
      ar = $urandom_range(0, 9);
      op = $urandom_range(0, 9);
      case (ar)
        0, 1, 2, 3: io_addr = 16'hFF00;
        4: io_addr = 16'hFF01;
        5: io_addr = 16'hFF02;
        6: io_addr = 16'hFF03;
        7: io_addr = 16'hFF04;
        8: io_addr = 16'hFF05;
        default: io_addr = 16'hFEFF;
      endcase
      io_dout = (ar == 6 || ar == 7) ? 16'($urandom_range(0, 31))
                                     : 16'($urandom);
      io_wr = (op <= 2 || op == 6);
      io_rd = (op >= 3 && op <= 6);
      tx_ready = ($urandom_range(0, 1) == 1);
      rx_valid = ($urandom_range(0, 1) == 1);
      rx_data = 16'($urandom);
      #1;
      chk("rnd rx_ready", {15'd0, rx_ready},
          {15'd0, (mrq.size() < 8) ||
                  (io_rd && !io_wr && io_addr == 16'hFF00)});
      model_step();
      @(posedge clk);
      #1;
      chk("rnd io_din", io_din, m_din);
      chk("rnd irq", {15'd0, irq}, {15'd0, m_irq});
      chk("rnd tx_valid", {15'd0, tx_valid},
          {15'd0, mtq.size() > 0});
      if (mtq.size() > 0) chk("rnd tx_data", tx_data, mtq[0]);
    end
    io_wr = 1'b0; io_rd = 1'b0;
    rx_valid = 1'b0; tx_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
